// File: rtl/compare_monitor.sv
// -----------------------------------------------------------------------------
// compare_monitor
//
// Sequential qualifier for the combinational 3-input compare result. The
// compare output is sampled every clock. A match is declared only after it
// has been high for RUN_LEN consecutive samples, so single-cycle glitches
// never reach the lab logic. Qualified matches are counted, and a sticky
// flag records any match that arrives after the event counter has already
// reached full scale.
//
// Parameters
//   CNT_W    width of run_cnt and event_cnt (default 8)
//   RUN_LEN  consecutive high samples needed for a match, 1 .. 2^CNT_W-1
//
// Optional feature
//   COMPARE_MONITOR_SYNC_EN  when defined, o_in passes through a 2-flop
//                            synchronizer before the FSM. All latencies then
//                            grow by two cycles. Use it when the compare
//                            inputs come from asynchronous switches.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   en           in   monitor enable; low holds the FSM in IDLE
//   clear        in   synchronous clear of counters, overflow and FSM
//   o_in         in   compare result from the upstream compare stage
//   match        out  high while the FSM is in MATCH (registered)
//   match_pulse  out  one-cycle pulse on the edge that enters MATCH
//   run_cnt      out  consecutive high samples, saturating
//   event_cnt    out  qualified match count, saturating
//   overflow     out  sticky: a match arrived while event_cnt was full
// -----------------------------------------------------------------------------
module compare_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             o_in,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_RUN_LEN = CNT_W'(RUN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RUN   = 2'd2,
    MATCH = 2'd3
  } state_t;

  // Increment that sticks at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == LP_CNT_MAX) begin
      return v;
    end
    return v + LP_ONE;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_next_run_cnt;
  logic [CNT_W-1:0] r_event_cnt;
  logic [CNT_W-1:0] w_next_event_cnt;
  logic             r_overflow;
  logic             w_next_overflow;
  logic             r_match_pulse;
  logic             w_next_match_pulse;
  logic             w_s;

  // ---------------------------------------------------------------------------
  // Stage p0/p1: optional input synchronizer feeding the sampled value w_s
  // ---------------------------------------------------------------------------
`ifdef COMPARE_MONITOR_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;

  // The synchronizer runs freely: clear and en only affect the FSM, so a
  // value already in flight is still delivered after a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= o_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_s = r_sync_p1;
`else
  assign w_s = o_in;
`endif

  // ---------------------------------------------------------------------------
  // Stage p2: qualifier FSM next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state       = r_state;
    w_next_run_cnt     = r_run_cnt;
    w_next_event_cnt   = r_event_cnt;
    w_next_overflow    = r_overflow;
    w_next_match_pulse = 1'b0;

    if (clear) begin
      // Clear beats everything, including an event on the same edge.
      w_next_state     = en ? WAIT : IDLE;
      w_next_run_cnt   = '0;
      w_next_event_cnt = '0;
      w_next_overflow  = 1'b0;
    end else if (!en) begin
      // Disabled: abandon any run but keep the event history.
      w_next_state   = IDLE;
      w_next_run_cnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The enabling edge only arms the monitor; w_s is not looked at.
          w_next_state   = WAIT;
          w_next_run_cnt = '0;
        end
        WAIT: begin
          if (w_s) begin
            w_next_run_cnt = LP_ONE;
            w_next_state   = (RUN_LEN == 1) ? MATCH : RUN;
          end else begin
            w_next_run_cnt = '0;
          end
        end
        RUN: begin
          if (w_s) begin
            w_next_run_cnt = sat_inc(r_run_cnt);
            if (w_next_run_cnt == LP_RUN_LEN) begin
              w_next_state = MATCH;
            end
          end else begin
            w_next_run_cnt = '0;
            w_next_state   = WAIT;
          end
        end
        MATCH: begin
          if (w_s) begin
            w_next_run_cnt = sat_inc(r_run_cnt);
          end else begin
            // Falling sample ends the match; a fresh run is needed.
            w_next_run_cnt = '0;
            w_next_state   = WAIT;
          end
        end
        default: begin
          w_next_state   = IDLE;
          w_next_run_cnt = '0;
        end
      endcase

      // Event bookkeeping happens only on the edge that enters MATCH.
      if ((w_next_state == MATCH) && (r_state != MATCH)) begin
        w_next_match_pulse = 1'b1;
        if (r_event_cnt == LP_CNT_MAX) begin
          w_next_overflow = 1'b1;
        end else begin
          w_next_event_cnt = sat_inc(r_event_cnt);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_run_cnt     <= '0;
      r_event_cnt   <= '0;
      r_overflow    <= 1'b0;
      r_match_pulse <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_run_cnt     <= w_next_run_cnt;
      r_event_cnt   <= w_next_event_cnt;
      r_overflow    <= w_next_overflow;
      r_match_pulse <= w_next_match_pulse;
    end
  end

  // match decodes the state register directly, so it is glitch-free.
  assign match       = (r_state == MATCH);
  assign match_pulse = r_match_pulse;
  assign run_cnt     = r_run_cnt;
  assign event_cnt   = r_event_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_compare_monitor.sv
module tb_compare_monitor;

  localparam int CNT_W = 8;
`ifdef COMPARE_MONITOR_SYNC_EN
  localparam int RUN_LEN = 1;
`else
  localparam int RUN_LEN = 3;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             clear;
  logic             o_in;
  logic             match;
  logic             match_pulse;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] event_cnt;
  logic             overflow;

  compare_monitor #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .o_in        (o_in),
    .match       (match),
    .match_pulse (match_pulse),
    .run_cnt     (run_cnt),
    .event_cnt   (event_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the length of the current high run as a plain integer,
  // a match being "run length has reached RUN_LEN".
  bit m_active;   // monitor armed (has spent one enabled edge since idle)
  int m_run;
  int m_evt;
  bit m_ovf;
  bit m_match;
  bit m_pulse;
  bit m_q0, m_q1; // delay line for the synchronized build

  typedef struct packed {
    logic       clr;
    logic       en;
    logic       o;
    logic       m;
    logic       p;
    logic [7:0] run;
    logic [7:0] evt;
    logic       ovf;
  } vec_t;

  vec_t tbl [0:25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_run    = 0;
    m_evt    = 0;
    m_ovf    = 1'b0;
    m_match  = 1'b0;
    m_pulse  = 1'b0;
    m_q0     = 1'b0;
    m_q1     = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit e, input bit o);
    bit s;
    bit was;
`ifdef COMPARE_MONITOR_SYNC_EN
    s    = m_q1;
    m_q1 = m_q0;
    m_q0 = o;
`else
    s = o;
`endif
    was = m_match;
    if (c) begin
      m_run = 0; m_evt = 0; m_ovf = 1'b0; m_pulse = 1'b0; m_match = 1'b0;
      m_active = e;
    end else if (!e) begin
      m_active = 1'b0; m_run = 0; m_pulse = 1'b0; m_match = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_run = 0; m_pulse = 1'b0; m_match = 1'b0;
    end else begin
      m_run   = s ? m_run + 1 : 0;
      m_match = (m_run >= RUN_LEN);
      m_pulse = m_match && !was;
      if (m_pulse) begin
        if (m_evt == CNT_MAX) m_ovf = 1'b1;
        else                  m_evt = m_evt + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int exp_run;
    exp_run = (m_run > CNT_MAX) ? CNT_MAX : m_run;
    chk({tag, ".match"},       32'(match),       32'(m_match));
    chk({tag, ".match_pulse"}, 32'(match_pulse), 32'(m_pulse));
    chk({tag, ".run_cnt"},     32'(run_cnt),     32'(exp_run));
    chk({tag, ".event_cnt"},   32'(event_cnt),   32'(m_evt));
    chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
  endtask

  // Drive inputs, take one rising edge, advance the model, settle.
  task automatic tick(input bit c, input bit e, input bit o);
    clear = c;
    en    = e;
    o_in  = o;
    @(posedge clk);
    model_edge(c, e, o);
    #1;
  endtask

  // Assert reset between edges and look at the outputs before any edge.
  task automatic reset_check(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, ".rst_match"},  32'(match),       32'd0);
    chk({tag, ".rst_pulse"},  32'(match_pulse), 32'd0);
    chk({tag, ".rst_run"},    32'(run_cnt),     32'd0);
    chk({tag, ".rst_evt"},    32'(event_cnt),   32'd0);
    chk({tag, ".rst_ovf"},    32'(overflow),    32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit lvl;
    reset = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    o_in  = 1'b0;
    model_reset();

    //                clr en o   m  p  run evt ovf
    tbl[0]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd0,8'd0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd2,8'd0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1, 8'd3,8'd1,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 8'd4,8'd1,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 8'd5,8'd1,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd2,8'd1,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd1,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd2,8'd1,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd1,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd2,8'd1,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b1, 1'b0,1'b0, 8'd0,8'd0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd0,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd2,8'd0,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1, 1'b1,1'b1, 8'd3,8'd1,1'b0};
    tbl[19] = '{1'b0,1'b0,1'b1, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[20] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[21] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd1,1'b0};
    tbl[22] = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 8'd0,8'd1,1'b0};
    tbl[23] = '{1'b1,1'b0,1'b1, 1'b0,1'b0, 8'd0,8'd0,1'b0};
    tbl[24] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd0,8'd0,1'b0};
    tbl[25] = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 8'd1,8'd0,1'b0};

    // Reset state, before any clock edge.
    #1;
    chk("init.match",  32'(match),       32'd0);
    chk("init.pulse",  32'(match_pulse), 32'd0);
    chk("init.run",    32'(run_cnt),     32'd0);
    chk("init.evt",    32'(event_cnt),   32'd0);
    chk("init.ovf",    32'(overflow),    32'd0);
    #12;
    reset = 1'b0;

`ifndef COMPARE_MONITOR_SYNC_EN
    // Directed table: qualified run, short pulses, clear and enable priority.
    for (int i = 0; i < 26; i++) begin
      tick(tbl[i].clr, tbl[i].en, tbl[i].o);
      chk($sformatf("vec%0d.match", i), 32'(match),       32'(tbl[i].m));
      chk($sformatf("vec%0d.pulse", i), 32'(match_pulse), 32'(tbl[i].p));
      chk($sformatf("vec%0d.run", i),   32'(run_cnt),     32'(tbl[i].run));
      chk($sformatf("vec%0d.evt", i),   32'(event_cnt),   32'(tbl[i].evt));
      chk($sformatf("vec%0d.ovf", i),   32'(overflow),    32'(tbl[i].ovf));
    end
`else
    // Synchronized build with RUN_LEN=1: pulse three edges after o_in rises.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("sync.edge1.pulse", 32'(match_pulse), 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    chk("sync.edge2.pulse", 32'(match_pulse), 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    chk("sync.edge3.pulse", 32'(match_pulse), 32'd1);
    chk("sync.edge3.match", 32'(match),       32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check_model("sync.tail");
`endif

    // Reset in the middle of a run, with a nonzero event count.
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      check_model("prerst");
    end
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check_model("midrun");
    reset_check("midrun");
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      check_model($sformatf("restart%0d", i));
    end
    tick(1'b0, 1'b1, 1'b0);

    // Event counter saturation and overflow, then clear.
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      check_model($sformatf("sat%0d", k));
      tick(1'b0, 1'b1, 1'b0);
      if (k == 255) begin
        chk("sat255.evt", 32'(event_cnt), 32'd255);
        chk("sat255.ovf", 32'(overflow),  32'd0);
      end
    end
    chk("sat256.evt", 32'(event_cnt), 32'd255);
    chk("sat256.ovf", 32'(overflow),  32'd1);
    tick(1'b1, 1'b1, 1'b0);
    chk("satclr.evt", 32'(event_cnt), 32'd0);
    chk("satclr.ovf", 32'(overflow),  32'd0);

    // Randomized traffic against the model.
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) lvl = ~lvl;
      if ($urandom_range(599) == 0) begin
        reset_check($sformatf("rnd%0d", i));
      end
      tick(($urandom_range(39) == 0), ($urandom_range(19) != 0), lvl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_monitor.md
# compare_monitor

Sequential qualifier placed directly downstream of the 3-input compare stage. It samples the compare result `o` every clock and declares a match only after `o` has stayed high for `RUN_LEN` consecutive samples. It counts qualified match events and flags counter saturation. It gives the lab design a registered, glitch-filtered view of the combinational compare output.

## Interface
- `CNT_W`, default 8: width of `run_cnt` and `event_cnt`.
- `RUN_LEN`, default 3: consecutive high samples required for a match. Legal range is 1 to 2^CNT_W−1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  monitor enable; when low, the FSM is held in IDLE.
- `clear`  in  1  synchronous clear of counters, overflow and FSM.
- `o_in`  in  1  compare result from the upstream compare stage.
- `match`  out  1  high while in state MATCH (registered).
- `match_pulse`  out  1  one-cycle pulse on the edge where MATCH is entered.
- `run_cnt`  out  CNT_W  current count of consecutive high samples; saturates at 2^CNT_W−1.
- `event_cnt`  out  CNT_W  number of qualified matches; saturates at 2^CNT_W−1.
- `overflow`  out  1  sticky; set when an event arrives while `event_cnt` is already at maximum.

## Operation
- **States:** IDLE, WAIT, RUN, MATCH.
- **Sampled value `s`:** `o_in` itself, or the synchronizer output when that option is compiled in (see Configuration).
- **Priority per edge (highest first):** `clear`, then `en` low, then normal update.
- **`clear` = 1:**
  - `run_cnt`, `event_cnt`, `overflow`, `match_pulse` go to 0.
  - State goes to WAIT if `en` = 1, otherwise IDLE.
- **`en` = 0:**
  - State goes to IDLE; `run_cnt` and `match_pulse` go to 0.
  - `event_cnt` and `overflow` hold their values.
- **IDLE:** goes to WAIT when `en` = 1. `s` is not evaluated on that edge.
- **WAIT:**
  - `s` = 1: `run_cnt` = 1; go to MATCH if `RUN_LEN` = 1, otherwise go to RUN.
  - `s` = 0: stay in WAIT.
- **RUN:**
  - `s` = 1: increment `run_cnt`. If the new value equals `RUN_LEN`, go to MATCH.
  - `s` = 0: `run_cnt` = 0; go to WAIT.
- **MATCH:**
  - `s` = 1: `run_cnt` keeps incrementing up to saturation; stay in MATCH.
  - `s` = 0: `run_cnt` = 0; go to WAIT.
- **On entry to MATCH:**
  - `match_pulse` = 1 for that one cycle.
  - `event_cnt` increments; if it is already at 2^CNT_W−1 it holds and `overflow` is set.
- **`match`:** equals (state == MATCH), registered.
- **Re-qualification:** once `s` falls, `match` drops on the same edge; a new run of `RUN_LEN` highs is needed to match again.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE, asynchronously, on `reset` assertion. Synchronizer flops also clear.
- **First edge after reset release:** IDLE → WAIT, provided `en` = 1.
- **Match latency:** with `o_in` high continuously from the edge sampled as run sample 1, `match` and `match_pulse` assert after edge number `RUN_LEN` of that run.
- **Deassertion:** `match` deasserts after the first edge that samples `s` = 0.
- **`clear` and event on the same edge:** `clear` wins. Counters end at 0 and `match_pulse` stays 0.
- **`reset` mid-run:** the run is abandoned and no pulse is emitted. Counting restarts from WAIT.

## Configuration
- **Macro:** `COMPARE_MONITOR_SYNC_EN`.
- **Defined:** `o_in` passes through a 2-flop synchronizer before the FSM. All latencies above increase by 2 cycles. Use this when the compare inputs are asynchronous switches.
- **Undefined:** the FSM samples `o_in` directly; no extra latency.

## Test plan
All scenarios use CNT_W=8, RUN_LEN=3, macro undefined, unless stated.

- **Reset:** assert `reset` mid-simulation → all outputs read 0 within the same time step, with no clock edge.
- **Qualified run:** `o_in` = 1 for 5 edges, then 0 → `match_pulse` is high for exactly 1 cycle after the 3rd edge; `match` is high for 3 cycles; `event_cnt` = 1; `run_cnt` steps 1,2,3,4,5 then 0.
- **Short pulses:** `o_in` = 1 for 2 edges, 0 for 1, 1 for 2 → `match` never asserts and `event_cnt` = 0.
- **Saturation:** 256 qualified runs → `event_cnt` = 255 after run 255; run 256 leaves it at 255 and sets `overflow` = 1; the following `clear` → `event_cnt` = 0 and `overflow` = 0.
- **Clear/enable priority:** `clear` on the edge that would enter MATCH → no pulse and `event_cnt` = 0. `en` = 0 during a run → state IDLE and `run_cnt` = 0, with `event_cnt` held.
- **Sync option and RUN_LEN=1:** with `COMPARE_MONITOR_SYNC_EN` defined and RUN_LEN=1, raise `o_in` → `match_pulse` asserts after the 3rd edge, i.e. 2 cycles later than in the undefined build.
